// File: rtl/vga_pixel_fetch_pkg.sv
// vga_pixel_fetch_pkg: shared frame constants, FSM states and pixel types for the VGA pixel fetcher.
package vga_pixel_fetch_pkg;
  localparam int unsigned FRAME_WORDS = 115200;
  localparam int unsigned FRAME_PIXELS = 76800;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned FIFO_CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CNT_W = 17;
  localparam int unsigned ADDR_W = 18;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_WAIT_FRAME} state_e;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;
  typedef struct packed {
    logic       v;
    logic [1:0] ph;
  } tag_t;
endpackage

// File: rtl/vga_pixel_fetch_fifo.sv
// pixel_fifo: synchronous FIFO with flush, simultaneous push/pop and occupancy count.
module pixel_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_pop, do_push;
  assign do_pop = pop_i && cnt_q != '0;
  assign do_push = push_i && (cnt_q != CW'(DEPTH) || do_pop);
  assign data_o = mem_q[rd_q];
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: streams RGB888 pixels from 3-word SRAM triplets into a pixel FIFO for VGA.
// Optional sticky underflow detection is built when PIXEL_FETCH_UNDERFLOW_EN is defined.
module vga_pixel_fetch
  import vga_pixel_fetch_pkg::*;
#(
  parameter int unsigned NUM_WORDS = FRAME_WORDS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              frame_start_i,
  input  logic [ADDR_W-1:0] base_address_i,
  output logic [ADDR_W-1:0] sram_address_o,
  output logic              sram_we_n_o,
  input  logic [15:0]       sram_read_data_i,
  input  logic              pixel_pop_i,
  output logic              pixel_valid_o,
  output logic [7:0]        pixel_r_o,
  output logic [7:0]        pixel_g_o,
  output logic [7:0]        pixel_b_o,
  output logic              frame_done_o,
  output logic              underflow_o
);
  localparam int unsigned NUM_PIXELS = NUM_WORDS / 3 * 2;
  state_e state_q;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [CNT_W-1:0] cnt_q, pop_cnt_q;
  logic [1:0] phase_q;
  tag_t tag1_q, tag2_q;
  logic [15:0] sav_q;
  logic frame_done_q;
  logic [FIFO_CW-1:0] fifo_cnt, inflight;
  logic fifo_empty, fifo_full;
  logic issue, last_word, push, pop_ok, final_pop;
  rgb24_t push_px, head_px;
  always_comb begin
    inflight = FIFO_CW'(tag1_q.v && tag1_q.ph != 2'd0) + FIFO_CW'(tag2_q.v && tag2_q.ph != 2'd0);
    issue = state_q == S_FETCH && enable_i && cnt_q < CNT_W'(NUM_WORDS) &&
            (phase_q != 2'd0 || fifo_cnt + inflight <= FIFO_CW'(FIFO_DEPTH - 2));
    last_word = cnt_q == CNT_W'(NUM_WORDS - 1);
    push = tag2_q.v && tag2_q.ph != 2'd0;
    push_px = tag2_q.ph == 2'd1 ? rgb24_t'({sav_q, sram_read_data_i[15:8]})
                                : rgb24_t'({sav_q[7:0], sram_read_data_i});
    pop_ok = pixel_pop_i && !frame_start_i && !fifo_empty;
    final_pop = pop_ok && pop_cnt_q == CNT_W'(NUM_PIXELS - 1);
  end
  pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(rgb24_t))) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (frame_start_i),
    .push_i  (push && enable_i && (!fifo_full || pop_ok)),
    .pop_i   (pixel_pop_i && !frame_start_i),
    .data_i  (push_px),
    .data_o  (head_px),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );
  // Tags follow each read through the two SRAM cycles; later assignments below take priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      base_q <= '0;
      addr_q <= '0;
      cnt_q <= '0;
      pop_cnt_q <= '0;
      phase_q <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
      sav_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      tag1_q <= {issue, phase_q};
      tag2_q <= tag1_q;
      frame_done_q <= 1'b0;
      if (tag2_q.v && tag2_q.ph != 2'd2) sav_q <= sram_read_data_i;
      if (pop_ok) pop_cnt_q <= pop_cnt_q + CNT_W'(1);
      if (issue) begin
        cnt_q <= cnt_q + CNT_W'(1);
        phase_q <= phase_q == 2'd2 ? 2'd0 : phase_q + 2'd1;
        if (!last_word) addr_q <= base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
      end
      if (issue && last_word) state_q <= S_DRAIN;
      if (state_q == S_DRAIN && final_pop) begin
        state_q <= S_WAIT_FRAME;
        frame_done_q <= 1'b1;
      end
      if (!enable_i) begin
        state_q <= S_IDLE;
        tag1_q <= '0;
        tag2_q <= '0;
      end
      if (frame_start_i) begin
        state_q <= enable_i ? S_FETCH : S_IDLE;
        base_q <= base_address_i;
        addr_q <= base_address_i;
        cnt_q <= '0;
        pop_cnt_q <= '0;
        phase_q <= '0;
        tag1_q <= '0;
        tag2_q <= '0;
      end
    end
  end
`ifdef PIXEL_FETCH_UNDERFLOW_EN
  logic underflow_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || frame_start_i) underflow_q <= 1'b0;
    else if (pixel_pop_i && fifo_empty) underflow_q <= 1'b1;
  end
  assign underflow_o = underflow_q;
`else
  assign underflow_o = 1'b0;
`endif
  assign sram_address_o = addr_q;
  assign sram_we_n_o = 1'b1;
  assign pixel_valid_o = !fifo_empty;
  assign pixel_r_o = head_px.r;
  assign pixel_g_o = head_px.g;
  assign pixel_b_o = head_px.b;
  assign frame_done_o = frame_done_q;
endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; all ports below are synchronous to Clock.
REQ-002 Clock  in  1  50 MHz system clock.
REQ-003 Reset  in  1  synchronous active-high reset.
REQ-004 Enable  in  1  level; high once decoding is finished and the display may fetch.
REQ-005 Frame_start  in  1  one-cycle pulse at vertical sync; restarts the frame.
REQ-006 Base_address  in  18  SRAM word address of the first RGB word; sampled on Frame_start.
REQ-007 SRAM_address  out  18  read address to the SRAM.
REQ-008 SRAM_we_n  out  1  write enable (active low); constant 1.
REQ-009 SRAM_read_data  in  16  SRAM data, valid 2 cycles after the address.
REQ-010 Pixel_pop  in  1  VGA side consumes one pixel this cycle.
REQ-011 Pixel_valid  out  1  FIFO non-empty; Pixel_R/G/B show the head pixel.
REQ-012 Pixel_R, Pixel_G, Pixel_B  out  8 each  head pixel colour.
REQ-013 Frame_done  out  1  one-cycle pulse when the last pixel of a frame is popped.
REQ-014 Underflow  out  1  sticky; a pop occurred while the FIFO was empty.

Function
REQ-015 Frame = 320x240 pixels = 115200 SRAM words; 3 words carry 2 pixels: w0={R0,G0}, w1={B0,R1}, w2={G1,B1}, high byte first.
REQ-016 States: S_IDLE, S_FETCH, S_DRAIN, S_WAIT_FRAME.
- S_IDLE -> S_FETCH on Frame_start with Enable=1.
- S_FETCH -> S_DRAIN after word 115199 is issued.
- S_DRAIN -> S_WAIT_FRAME on the pop of pixel 76799.
- S_WAIT_FRAME -> S_FETCH on Frame_start.
REQ-017 On Frame_start: load the word counter with 0 and SRAM_address with Base_address, flush the FIFO, discard in-flight reads.
REQ-018 In S_FETCH, issue one read per cycle, address = Base_address + word counter, only while (FIFO free pixels - in-flight pixels) >= 2 at a triplet boundary; a started triplet always completes.
REQ-019 The read pipeline SHALL tag each issued read with its triplet phase (0/1/2) delayed 2 cycles; pixel 0 is pushed on phase 1 data, pixel 1 on phase 2 data.
REQ-020 FIFO depth 8 pixels x 24 bits; worst-case latency from first read to Pixel_valid = 4 cycles (address, 2-cycle SRAM, push).
REQ-021 A pop and a push in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-022 A pop on an empty FIFO SHALL leave outputs unchanged and set Underflow.
REQ-023 Frame_start together with Pixel_pop: Frame_start wins and the pop is ignored.
REQ-024 Enable low: no new reads are issued; in-flight data is discarded; go to S_IDLE next cycle.
REQ-025 The word counter SHALL saturate at 115200 (no wrap); the address adder is 18-bit modulo.
REQ-026 Frame_done asserts for exactly one cycle, in the cycle after the final pop.

Reset
REQ-027 Reset SHALL give state S_IDLE, an empty FIFO, zeroed counters and pipeline tags, and SRAM_address=0.
REQ-028 Reset SHALL also give SRAM_we_n=1, Pixel_valid=0, Pixel_R/G/B=0, Frame_done=0, Underflow=0.
REQ-029 Reset mid-frame SHALL abandon the frame; fetching resumes only on the next Frame_start.

Configuration
REQ-030 Macro PIXEL_FETCH_UNDERFLOW_EN.
- Defined: Underflow is sticky per REQ-022 and clears on Frame_start or Reset.
- Undefined: Underflow is tied to 0 and no detection logic is synthesised.

Structure
REQ-031 Package vga_pixel_fetch_pkg SHALL hold FRAME_WORDS=115200, FRAME_PIXELS=76800, FIFO_DEPTH=8, the state enum, and a packed rgb24 typedef.
REQ-032 The FIFO SHALL be a sub-module, pixel_fifo (parameterised depth and width, push/pop/full/empty/count).

Verification
REQ-033 Reset, then Frame_start with Base_address=146944 and Enable=1 -> first SRAM_address=146944, Pixel_valid high on cycle 4.
REQ-034 SRAM words 0xFF10, 0x2030, 0x4050 at the base -> pixels (FF,10,20) then (30,40,50).
REQ-035 Pop every 2nd cycle for a full frame -> 76800 pixels, exactly one Frame_done, Underflow=0, last address = base+115199.
REQ-036 Pixel_pop held with no Frame_start -> Underflow=1 (macro defined), 0 (macro undefined).
REQ-037 Frame_start mid-frame (after 5000 pops) -> FIFO empties, address returns to base, first pixel repeats the word-0 data.
REQ-038 Reset asserted while 3 reads are in flight -> no push occurs after reset, all outputs at REQ-027/028 values.
